// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared constants for the FIFO read-side drain controller
package fifo_drain_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int OBUF_DEPTH = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int THRESH     = 8;

endpackage

// File: rtl/fifo_drain_obuf.sv
// rtl/fifo_drain_obuf.sv - 2-entry valid/ready output buffer with occupancy
module fifo_drain_obuf
  import fifo_drain_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_tvalid,
  input  logic [DW-1:0] s_tdata,
  output logic          m_tvalid,
  output logic [DW-1:0] m_tdata,
  input  logic          m_tready,
  output logic [1:0]    occ
);

  logic [DW-1:0] mem_q [OBUF_DEPTH];
  logic [DW-1:0] mem_d [OBUF_DEPTH];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    occ_q, occ_d;
  logic          push, pop;

  assign m_tvalid = (occ_q != 2'd0);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign occ      = occ_q;
  assign pop      = m_tvalid & m_tready;
  // A full buffer may still take a word in the same cycle its head leaves.
  assign push     = s_tvalid & ((occ_q != 2'(OBUF_DEPTH)) | pop);

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = s_tdata;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - burst/flush read controller for the 16x8 FIFO
// Optional FIFO_DRAIN_STATS_EN adds words_out and bursts counters.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int DW            = 8,
  parameter int BURST_LEN     = 8,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_data,
  input  logic          fifo_empty,
  input  logic          fifo_threshold,
  input  logic          fifo_underflow,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          busy,
  output logic          err_underflow
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]   words_out,
  output logic [15:0]   bursts
`endif
);

  localparam int IW = $clog2(FLUSH_TIMEOUT);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(FLUSH_TIMEOUT - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          rd_pending_q, rd_pending_d;
  logic          err_q, err_d;
  logic [1:0]    occ;
  logic [2:0]    fill;
  logic          pop, can_pop, popping_state;

  fifo_drain_obuf #(.DW(DW)) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (rd_pending_q),
    .s_tdata  (fifo_data),
    .m_tvalid (m_valid),
    .m_tdata  (m_data),
    .m_tready (m_ready),
    .occ      (occ)
  );

  // Words already buffered or on their way, less the one leaving this cycle.
  assign pop           = m_valid & m_ready;
  assign fill          = {1'b0, occ} + {2'b0, rd_pending_q} - {2'b0, pop};
  assign can_pop       = (fill < 3'd2);
  assign popping_state = (state_q == ST_BURST) | (state_q == ST_DRAIN);
  assign fifo_rd       = can_pop & ~fifo_empty & popping_state & en;

  assign busy          = (state_q != ST_IDLE) | rd_pending_q | (occ != 2'd0);
  assign err_underflow = err_q;

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    rd_pending_d = fifo_rd;
    err_d        = err_q | fifo_underflow;
    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        if (fifo_empty | fifo_threshold) idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + IW'(1);
        if (en & fifo_threshold) begin
          state_d    = ST_BURST;
          idle_cnt_d = '0;
        end else if (en & ~fifo_empty & (idle_cnt_q == IDLE_MAX)) begin
          state_d    = ST_DRAIN;
          idle_cnt_d = '0;
        end
      end
      ST_BURST: begin
        idle_cnt_d = '0;
        if (fifo_rd) burst_cnt_d = burst_cnt_q + BW'(1);
        if (~en | (fifo_rd & (burst_cnt_q == BURST_LAST)) | (fifo_empty & ~fifo_rd))
          state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        idle_cnt_d = '0;
        if (fifo_empty | ~en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      burst_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      rd_pending_q <= rd_pending_d;
      err_q        <= err_d;
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] words_out_q, words_out_d;
  logic [15:0] bursts_q, bursts_d;

  always_comb begin
    words_out_d = words_out_q + {15'd0, pop};
    bursts_d    = bursts_q + {15'd0, (state_q == ST_IDLE) & (state_d != ST_IDLE)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_out_q <= 16'd0;
      bursts_q    <= 16'd0;
    end else begin
      words_out_q <= words_out_d;
      bursts_q    <= bursts_d;
    end
  end

  assign words_out = words_out_q;
  assign bursts    = bursts_q;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - directed self-checking bench for fifo_drain_ctrl
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, m_ready, wr, force_uf;
  logic [7:0] wr_data;
  logic       fifo_rd, fifo_empty, fifo_threshold, fifo_underflow;
  logic [7:0] fifo_data, m_data;
  logic       m_valid, busy, err_underflow;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] words_out, bursts;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_log[$];
  logic [7:0] got[$];
  int got_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_drain_ctrl #(.DW(8), .BURST_LEN(8), .FLUSH_TIMEOUT(64)) dut (
`ifdef FIFO_DRAIN_STATS_EN
    .words_out      (words_out),
    .bursts         (bursts),
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .fifo_rd        (fifo_rd),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .fifo_underflow (fifo_underflow),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .busy           (busy),
    .err_underflow  (err_underflow)
  );

  // 16x8 FIFO model: registered data_out, updated the cycle after rd
  logic [7:0] fmem [16];
  logic [3:0] frp, fwp;
  logic [4:0] fcount;
  logic [7:0] fdout;
  logic       uf_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frp <= 4'd0; fwp <= 4'd0; fcount <= 5'd0; fdout <= 8'd0; uf_q <= 1'b0;
    end else begin
      if (wr) begin fmem[fwp] <= wr_data; fwp <= fwp + 4'd1; end
      if (fifo_rd && fcount != 5'd0) begin fdout <= fmem[frp]; frp <= frp + 4'd1; end
      uf_q   <= fifo_rd && (fcount == 5'd0);
      fcount <= fcount + {4'd0, wr} - {4'd0, (fifo_rd && fcount != 5'd0)};
    end
  end

  assign fifo_data      = fdout;
  assign fifo_empty     = (fcount == 5'd0);
  assign fifo_threshold = (fcount >= 5'd8);
  assign fifo_underflow = uf_q | force_uf;

  always @(negedge clk) begin
    if (fifo_rd) rd_log.push_back(cyc);
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b1; wr = 1'b0; wr_data = 8'd0; force_uf = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic wait_got(input string tag, input int g_b, input int n, input int budget);
    for (int i = 0; i < budget && got.size() < g_b + n; i++) tick();
    check(tag, got.size() - g_b, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd_b, g_b, w0;
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b1; wr = 1'b0; wr_data = 8'd0; force_uf = 1'b0;
    tick(); tick();
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_underflow, 0);
    rst_n = 1'b1;
    tick();

    // single threshold burst
    rd_b = rd_log.size(); g_b = got.size();
    load(8'h00, 8);
    en = 1'b1;
    wait_got("t1_words", g_b, 8, 40);
    check("t1_pops", rd_log.size() - rd_b, 8);
    check("t1_span", rd_log[rd_b+7] - rd_log[rd_b], 7);
    check("t1_latency", got_cyc[g_b] - rd_log[rd_b], 2);
    for (int i = 0; i < 8; i++) check("t1_data", got[g_b+i], i);
    repeat (3) tick();
    check("t1_busy", busy, 0);

    // two back-to-back bursts
    do_reset();
    rd_b = rd_log.size(); g_b = got.size();
    load(8'h10, 16);
    en = 1'b1;
    wait_got("t2_words", g_b, 16, 60);
    check("t2_pops", rd_log.size() - rd_b, 16);
    check("t2_gap", rd_log[rd_b+8] - rd_log[rd_b+7], 2);
    check("t2_span2", rd_log[rd_b+15] - rd_log[rd_b+8], 7);
    for (int i = 0; i < 16; i++) check("t2_data", got[g_b+i], 8'h10 + i);
    check("t2_err", err_underflow, 0);

    // backpressure
    do_reset();
    m_ready = 1'b0;
    rd_b = rd_log.size(); g_b = got.size();
    load(8'h00, 8);
    en = 1'b1;
    repeat (10) tick();
    check("t3_stall_pops", rd_log.size() - rd_b, 2);
    check("t3_valid", m_valid, 1);
    check("t3_hold_a", m_data, 8'h00);
    repeat (3) tick();
    check("t3_hold_b", m_data, 8'h00);
    check("t3_no_hs", got.size() - g_b, 0);
    m_ready = 1'b1;
    wait_got("t3_words", g_b, 8, 40);
    for (int i = 0; i < 8; i++) check("t3_data", got[g_b+i], i);
    check("t3_pops", rd_log.size() - rd_b, 8);

    // idle flush of a partial FIFO
    do_reset();
    en = 1'b1;
    rd_b = rd_log.size(); g_b = got.size();
    w0 = cyc;
    load(8'h40, 3);
    wait_got("t4_words", g_b, 3, 120);
    check("t4_first_rd", rd_log[rd_b] - w0, 65);
    for (int i = 0; i < 3; i++) check("t4_data", got[g_b+i], 8'h40 + i);
    repeat (5) tick();
    check("t4_pops", rd_log.size() - rd_b, 3);
    check("t4_busy", busy, 0);
    check("t4_err", err_underflow, 0);

    // enable dropped mid-burst
    do_reset();
    rd_b = rd_log.size(); g_b = got.size();
    load(8'h00, 8);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_log.size() - rd_b >= 3) break;
    end
    en = 1'b0;
    repeat (10) tick();
    check("t5_pops_off", rd_log.size() - rd_b, 3);
    check("t5_words_off", got.size() - g_b, 3);
    check("t5_third", got[g_b+2], 8'h02);
    check("t5_busy_off", busy, 0);
    en = 1'b1;
    wait_got("t5_words", g_b, 8, 120);
    for (int i = 3; i < 8; i++) check("t5_data", got[g_b+i], i);
    check("t5_pops", rd_log.size() - rd_b, 8);

    // sticky underflow, then reset mid-burst
    do_reset();
    force_uf = 1'b1;
    tick();
    force_uf = 1'b0;
    tick();
    check("t6_err_set", err_underflow, 1);
    repeat (5) tick();
    check("t6_err_sticky", err_underflow, 1);
    load(8'h00, 8);
    en = 1'b1;
    repeat (4) tick();
    check("t6_busy_mid", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_fifo_rd", fifo_rd, 0);
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_data", m_data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err_underflow, 0);
    tick();
    rst_n = 1'b1;
    en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
